// File: rtl/axi4s_upsizer.sv
// AXI4-Stream 1:4 width upsizer: packs up to four narrow beats into one wide beat,
// closing a group early on tlast and zero-filling the unused upper lanes.
module axi4s_upsizer #(
  parameter int unsigned SRC_DATA_WIDTH = 64,
  parameter int unsigned DST_DATA_WIDTH = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          axis_in_tvalid,
  output logic                          axis_in_tready,
  input  logic [SRC_DATA_WIDTH-1:0]     axis_in_tdata,
  input  logic [SRC_DATA_WIDTH/8-1:0]   axis_in_tkeep,
  input  logic [SRC_DATA_WIDTH/8-1:0]   axis_in_tstrb,
  input  logic                          axis_in_tlast,
  input  logic [3:0]                    axis_in_tid,
  input  logic [3:0]                    axis_in_tdest,
  input  logic [3:0]                    axis_in_tuser,
  output logic                          axis_out_tvalid,
  input  logic                          axis_out_tready,
  output logic [DST_DATA_WIDTH-1:0]     axis_out_tdata,
  output logic [DST_DATA_WIDTH/8-1:0]   axis_out_tkeep,
  output logic [DST_DATA_WIDTH/8-1:0]   axis_out_tstrb,
  output logic                          axis_out_tlast,
  output logic [3:0]                    axis_out_tid,
  output logic [3:0]                    axis_out_tdest,
  output logic [15:0]                   axis_out_tuser
);

  localparam int unsigned RATIO    = 4;
  localparam int unsigned LANE_W   = 2;
  localparam int unsigned SKEEP_W  = SRC_DATA_WIDTH / 8;
  localparam int unsigned DKEEP_W  = DST_DATA_WIDTH / 8;
  localparam int unsigned SUSER_W  = 4;
  localparam int unsigned DUSER_W  = SUSER_W * RATIO;

  if (DST_DATA_WIDTH != RATIO * SRC_DATA_WIDTH) begin : g_width_check
    $error("axi4s_upsizer: DST_DATA_WIDTH must be 4*SRC_DATA_WIDTH");
  end

  // Accumulator
  logic [DST_DATA_WIDTH-1:0] acc_data;
  logic [DKEEP_W-1:0]        acc_keep;
  logic [DKEEP_W-1:0]        acc_strb;
  logic [DUSER_W-1:0]        acc_user;
  logic [LANE_W-1:0]         lane_cnt;
  logic [3:0]                acc_tid;
  logic [3:0]                acc_tdest;
  logic                      acc_last;
  logic                      acc_done;

  // Output register
  logic [DST_DATA_WIDTH-1:0] out_data;
  logic [DKEEP_W-1:0]        out_keep;
  logic [DKEEP_W-1:0]        out_strb;
  logic [DUSER_W-1:0]        out_user;
  logic [3:0]                out_tid;
  logic [3:0]                out_tdest;
  logic                      out_last;
  logic                      out_valid;

  // Accumulator contents with the current input beat merged into its lane
  logic [DST_DATA_WIDTH-1:0] m_data;
  logic [DKEEP_W-1:0]        m_keep;
  logic [DKEEP_W-1:0]        m_strb;
  logic [DUSER_W-1:0]        m_user;
  logic [3:0]                m_tid;
  logic [3:0]                m_tdest;

  logic in_fire, group_done, out_fire, out_free, load_acc, load_in;

  assign axis_in_tready = rst_n & ~acc_done;
  assign in_fire        = axis_in_tvalid & axis_in_tready;
  assign group_done     = in_fire & ((lane_cnt == LANE_W'(RATIO - 1)) | axis_in_tlast);
  assign out_fire       = out_valid & axis_out_tready;
  assign out_free       = ~out_valid | out_fire;
  assign load_acc       = acc_done & out_free;
  assign load_in        = group_done & out_free;

  // Lanes above the written one are already zero: the accumulator is cleared per group
  always_comb begin
    m_data  = acc_data;
    m_keep  = acc_keep;
    m_strb  = acc_strb;
    m_user  = acc_user;
    m_tid   = (lane_cnt == '0) ? axis_in_tid   : acc_tid;
    m_tdest = (lane_cnt == '0) ? axis_in_tdest : acc_tdest;
    for (int unsigned l = 0; l < RATIO; l++) begin
      if (lane_cnt == LANE_W'(l)) begin
        m_data[l*SRC_DATA_WIDTH +: SRC_DATA_WIDTH] = axis_in_tdata;
        m_keep[l*SKEEP_W +: SKEEP_W]               = axis_in_tkeep;
        m_strb[l*SKEEP_W +: SKEEP_W]               = axis_in_tstrb;
        m_user[l*SUSER_W +: SUSER_W]               = axis_in_tuser;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data  <= '0;
      acc_keep  <= '0;
      acc_strb  <= '0;
      acc_user  <= '0;
      acc_tid   <= '0;
      acc_tdest <= '0;
      acc_last  <= 1'b0;
      acc_done  <= 1'b0;
      lane_cnt  <= '0;
    end else if (load_acc || load_in) begin
      acc_data  <= '0;
      acc_keep  <= '0;
      acc_strb  <= '0;
      acc_user  <= '0;
      acc_tid   <= '0;
      acc_tdest <= '0;
      acc_last  <= 1'b0;
      acc_done  <= 1'b0;
      lane_cnt  <= '0;
    end else if (in_fire) begin
      acc_data  <= m_data;
      acc_keep  <= m_keep;
      acc_strb  <= m_strb;
      acc_user  <= m_user;
      acc_tid   <= m_tid;
      acc_tdest <= m_tdest;
      if (group_done) begin
        acc_last <= axis_in_tlast;
        acc_done <= 1'b1;
      end else begin
        lane_cnt <= lane_cnt + LANE_W'(1);
      end
    end
  end

  // Output beat: a parked group has priority, otherwise the completing input bypasses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_strb  <= '0;
      out_user  <= '0;
      out_tid   <= '0;
      out_tdest <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_acc) begin
      out_data  <= acc_data;
      out_keep  <= acc_keep;
      out_strb  <= acc_strb;
      out_user  <= acc_user;
      out_tid   <= acc_tid;
      out_tdest <= acc_tdest;
      out_last  <= acc_last;
      out_valid <= 1'b1;
    end else if (load_in) begin
      out_data  <= m_data;
      out_keep  <= m_keep;
      out_strb  <= m_strb;
      out_user  <= m_user;
      out_tid   <= m_tid;
      out_tdest <= m_tdest;
      out_last  <= axis_in_tlast;
      out_valid <= 1'b1;
    end else if (out_fire) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_strb  <= '0;
      out_user  <= '0;
      out_tid   <= '0;
      out_tdest <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end
  end

  assign axis_out_tvalid = out_valid;
  assign axis_out_tdata  = out_data;
  assign axis_out_tkeep  = out_keep;
  assign axis_out_tstrb  = out_strb;
  assign axis_out_tuser  = out_user;
  assign axis_out_tid    = out_tid;
  assign axis_out_tdest  = out_tdest;
  assign axis_out_tlast  = out_last;

endmodule

// File: tb/tb_axi4s_upsizer.sv
// Scoreboard bench for axi4s_upsizer: a group-level reference model fills an
// expectation queue on each accepted beat; a monitor checks every output beat.
module tb_axi4s_upsizer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         axis_in_tvalid, axis_in_tready, axis_in_tlast;
  logic [63:0]  axis_in_tdata;
  logic [7:0]   axis_in_tkeep, axis_in_tstrb;
  logic [3:0]   axis_in_tid, axis_in_tdest, axis_in_tuser;
  logic         axis_out_tvalid, axis_out_tready, axis_out_tlast;
  logic [255:0] axis_out_tdata;
  logic [31:0]  axis_out_tkeep, axis_out_tstrb;
  logic [3:0]   axis_out_tid, axis_out_tdest;
  logic [15:0]  axis_out_tuser;

  always #5 clk = ~clk;

  axi4s_upsizer #(.SRC_DATA_WIDTH(64), .DST_DATA_WIDTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep),
    .axis_in_tstrb(axis_in_tstrb), .axis_in_tlast(axis_in_tlast),
    .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest), .axis_in_tuser(axis_in_tuser),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep),
    .axis_out_tstrb(axis_out_tstrb), .axis_out_tlast(axis_out_tlast),
    .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest), .axis_out_tuser(axis_out_tuser)
  );

  typedef struct {
    logic [63:0] d; logic [7:0] k; logic [7:0] s;
    logic [3:0] u; logic [3:0] id; logic [3:0] de; logic l;
  } beat_t;

  typedef struct {
    logic [255:0] d; logic [31:0] k; logic [31:0] s;
    logic [15:0] u; logic [3:0] id; logic [3:0] de; logic l;
  } obeat_t;

  beat_t  grp_q[$];
  obeat_t exp_q[$];
  int tests = 0, fails = 0;
  int accepted = 0, stalls = 0, out_beats = 0;
  bit rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: a group is the run of accepted beats closed by the 4th beat or tlast
  function automatic void model_accept(input beat_t b);
    obeat_t e;
    grp_q.push_back(b);
    if (grp_q.size() == 4 || b.l) begin
      e.d = '0; e.k = '0; e.s = '0; e.u = '0;
      for (int i = 0; i < grp_q.size(); i++) begin
        e.d[64*i +: 64] = grp_q[i].d;
        e.k[8*i +: 8]   = grp_q[i].k;
        e.s[8*i +: 8]   = grp_q[i].s;
        e.u[4*i +: 4]   = grp_q[i].u;
      end
      e.id = grp_q[0].id;
      e.de = grp_q[0].de;
      e.l  = b.l;
      exp_q.push_back(e);
      grp_q.delete();
    end
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the beat
  task automatic send(input beat_t b);
    int n;
    axis_in_tvalid = 1'b1;
    axis_in_tdata = b.d; axis_in_tkeep = b.k; axis_in_tstrb = b.s;
    axis_in_tuser = b.u; axis_in_tid = b.id; axis_in_tdest = b.de; axis_in_tlast = b.l;
    @(negedge clk);
    n = 0;
    while (!axis_in_tready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n > 0) stalls++;
    if (!axis_in_tready) chk("in_accept_timeout", 256'(0), 256'(1));
    else begin
      model_accept(b);
      accepted++;
    end
    @(posedge clk); #1;
    axis_in_tvalid = 1'b0;
  endtask

  function automatic beat_t mk(input logic [63:0] d, input logic [7:0] k, input logic [3:0] u,
                               input logic [3:0] id, input logic [3:0] de, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.s = k; b.u = u; b.id = id; b.de = de; b.l = l;
    return b;
  endfunction

  // Monitor: scoreboard pop on each transfer, idle-zero and stall-hold rules
  logic [255:0] prev_d;
  logic [92:0]  prev_side;
  bit           prev_stall = 1'b0;
  initial begin
    obeat_t e;
    forever begin
      @(negedge clk);
      if (axis_out_tvalid && axis_out_tready) begin
        out_beats++;
        if (exp_q.size() == 0) chk("unexpected_out_beat", 256'(1), 256'(0));
        else begin
          e = exp_q.pop_front();
          chk("out_tdata", axis_out_tdata, e.d);
          chk("out_tkeep", 256'(axis_out_tkeep), 256'(e.k));
          chk("out_tstrb", 256'(axis_out_tstrb), 256'(e.s));
          chk("out_tuser", 256'(axis_out_tuser), 256'(e.u));
          chk("out_tid_tdest_tlast", 256'({axis_out_tid, axis_out_tdest, axis_out_tlast}),
              256'({e.id, e.de, e.l}));
        end
      end
      if (!axis_out_tvalid)
        chk("idle_payload_zero", 256'(|{axis_out_tdata, axis_out_tkeep, axis_out_tstrb,
            axis_out_tlast, axis_out_tid, axis_out_tdest, axis_out_tuser}), 256'(0));
      if (prev_stall) begin
        chk("stall_hold_data", axis_out_tdata, prev_d);
        chk("stall_hold_side", 256'({axis_out_tkeep, axis_out_tstrb, axis_out_tuser,
            axis_out_tid, axis_out_tdest, axis_out_tlast}), 256'(prev_side));
      end
      prev_stall = rst_n && axis_out_tvalid && !axis_out_tready;
      prev_d     = axis_out_tdata;
      prev_side  = {axis_out_tkeep, axis_out_tstrb, axis_out_tuser, axis_out_tid,
                    axis_out_tdest, axis_out_tlast};
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) axis_out_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] c27;
    logic [63:0]  rd [4];
    logic [255:0] rexp;
    int n;
    int ob0;
    beat_t b;

    rst_n = 1'b0; axis_out_tready = 1'b0; axis_in_tvalid = 1'b0;
    axis_in_tdata = '0; axis_in_tkeep = '0; axis_in_tstrb = '0; axis_in_tlast = 1'b0;
    axis_in_tid = '0; axis_in_tdest = '0; axis_in_tuser = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_tready", 256'(axis_in_tready), 256'(0));
    chk("reset_out_tvalid", 256'(axis_out_tvalid), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_tready", 256'(axis_in_tready), 256'(1));
    @(posedge clk); #1;

    // Full four-beat packet, one-cycle latency
    axis_out_tready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(mk(64'h1111_1111_1111_1111 * 64'(i + 1), 8'hFF, 4'(i + 1), 4'd0, 4'd0, i == 3));
    @(negedge clk);
    c27 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    chk("full_latency_valid", 256'(axis_out_tvalid), 256'(1));
    chk("full_tdata", axis_out_tdata, c27);
    chk("full_tkeep", 256'(axis_out_tkeep), 256'(32'hFFFF_FFFF));
    chk("full_tuser", 256'(axis_out_tuser), 256'(16'h4321));
    chk("full_tlast", 256'(axis_out_tlast), 256'(1));
    @(posedge clk); #1;

    // Two-beat packet with partial keep on the last beat
    send(mk({$urandom, $urandom}, 8'hFF, 4'hA, 4'd1, 4'd2, 1'b0));
    send(mk({$urandom, $urandom}, 8'h0F, 4'hB, 4'd1, 4'd2, 1'b1));
    @(negedge clk);
    chk("short_tkeep", 256'(axis_out_tkeep), 256'(32'h0000_0FFF));
    chk("short_upper_data", 256'(axis_out_tdata[255:128]), 256'(0));
    chk("short_upper_user", 256'(axis_out_tuser[15:8]), 256'(0));
    chk("short_tlast", 256'(axis_out_tlast), 256'(1));
    @(posedge clk); #1;

    // Single-beat packet
    send(mk(64'hDEAD_BEEF_0123_4567, 8'hFF, 4'h7, 4'd5, 4'd9, 1'b1));
    @(negedge clk);
    chk("single_tkeep", 256'(axis_out_tkeep), 256'(32'h0000_00FF));
    chk("single_tid_tdest", 256'({axis_out_tid, axis_out_tdest}), 256'({4'd5, 4'd9}));
    chk("single_tlast", 256'(axis_out_tlast), 256'(1));
    @(posedge clk); #1;

    // Twelve back-to-back beats with the sink always ready
    stalls = 0; ob0 = out_beats;
    for (int i = 0; i < 12; i++)
      send(mk({$urandom, $urandom}, 8'hFF, 4'(i), 4'd3, 4'd4, i == 11));
    repeat (3) @(posedge clk); #1;
    chk("b2b_no_stall", 256'(stalls), 256'(0));
    chk("b2b_out_beats", 256'(out_beats - ob0), 256'(3));

    // Blocked sink: two groups absorbed, then backpressure, then drain
    axis_out_tready = 1'b0; accepted = 0;
    fork
      for (int i = 0; i < 12; i++)
        send(mk({$urandom, $urandom}, 8'hFF, 4'(i), 4'd6, 4'd7, i == 11));
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", 256'(accepted), 256'(8));
        chk("bp_in_tready", 256'(axis_in_tready), 256'(0));
        chk("bp_out_valid", 256'(axis_out_tvalid), 256'(1));
        @(posedge clk); #1;
        axis_out_tready = 1'b1;
        @(negedge clk);
        chk("bp_release_beat1", 256'(axis_out_tvalid), 256'(1));
        @(negedge clk);
        chk("bp_release_beat2", 256'(axis_out_tvalid), 256'(1));
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("bp_total_accepted", 256'(accepted), 256'(12));

    // Reset in the middle of a group
    send(mk({8{8'hAA}}, 8'hFF, 4'hF, 4'd1, 4'd1, 1'b0));
    send(mk({8{8'hBB}}, 8'hFF, 4'hF, 4'd1, 4'd1, 1'b0));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_tready", 256'(axis_in_tready), 256'(0));
    chk("midrst_out_tvalid", 256'(axis_out_tvalid), 256'(0));
    grp_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_tready", 256'(axis_in_tready), 256'(1));
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rd[i] = {$urandom, $urandom};
      send(mk(rd[i], 8'hFF, 4'(i), 4'd2, 4'd3, i == 3));
    end
    @(negedge clk);
    rexp = {rd[3], rd[2], rd[1], rd[0]};
    chk("midrst_clean_group", axis_out_tdata, rexp);
    @(posedge clk); #1;

    // Randomized traffic with random sink backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      b = mk({$urandom, $urandom}, 8'($urandom_range(1, 255)), 4'($urandom),
             4'($urandom), 4'($urandom), ($urandom_range(0, 4) == 0) || (i == 299));
      b.s = 8'($urandom) & b.k;
      send(b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    axis_out_tready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 256'(exp_q.size()), 256'(0));
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
